// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, datapath width and sequencer state encoding
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_NOT     = 3'b101;
  localparam logic [2:0] OP_SHL     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
endpackage

// File: rtl/regfile4x8.sv
// regfile4x8: register file with sync write, two combinational read ports and a debug read port
module regfile4x8 import cpu_pkg::*; #(
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] mem [NREGS];
  always_ff @(posedge clk) begin
    if (rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  end
  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one request at a time to the combinational ALU and writes back the result; ALU_SEQ_FLAGS_EN adds zero/sign flags
module alu_sequencer import cpu_pkg::*; #(
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [AW-1:0]     req_dst,
  input  logic [AW-1:0]     req_src1,
  input  logic [AW-1:0]     req_src2,
  input  logic              req_imm_sel,
  input  logic [DATA_W-1:0] req_imm,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  output logic [2:0]        alu_operation,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              done_err,
  output logic [DATA_W-1:0] done_data,
  input  logic [AW-1:0]     rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic              flag_z,
  output logic              flag_n
);
  state_t state, state_nx;
  logic [AW-1:0] dst_q;
  logic [DATA_W-1:0] rd1, rd2;
  logic err_q, acc, we, illegal;
  regfile4x8 #(.NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst), .we(we), .waddr(dst_q), .wdata(alu_result),
    .raddr1(req_src1), .rdata1(rd1), .raddr2(req_src2), .rdata2(rd2),
    .dbg_addr(rf_rd_addr), .dbg_data(rf_rd_data)
  );
  assign req_ready  = state == S_IDLE;
  assign acc        = req_valid && req_ready;
  assign illegal    = req_op == OP_ILLEGAL;
  assign we         = state == S_ISSUE;
  assign alu_enable = we;
  assign done       = state == S_DONE;
  assign done_err   = done && err_q;
  always_comb begin
    state_nx = S_IDLE;
    if (state == S_IDLE) state_nx = acc ? (illegal ? S_DONE : S_ISSUE) : S_IDLE;
    else if (state == S_ISSUE) state_nx = S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end
  // operand latches double as the ALU bus so it stays quiet outside ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_operation <= '0;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      dst_q         <= '0;
      err_q         <= 1'b0;
      done_data     <= '0;
    end else begin
      if (acc) begin
        alu_operation <= req_op;
        alu_operand1  <= rd1;
        alu_operand2  <= req_imm_sel ? req_imm : rd2;
        dst_q         <= req_dst;
        err_q         <= illegal;
        if (illegal) done_data <= '0;
      end
      if (we) done_data <= alu_result;
    end
  end
`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (we) begin
      flag_z <= alu_result == '0;
      flag_n <= alu_result[DATA_W-1];
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random requests checked against an architectural register-file model
module tb_alu_sequencer;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_imm_sel = 0;
  logic [2:0] req_op = 0, alu_operation;
  logic [1:0] req_dst = 0, req_src1 = 0, req_src2 = 0, rf_rd_addr = 0;
  logic [7:0] req_imm = 0, alu_operand1, alu_operand2, alu_result, done_data, rf_rd_data;
  logic alu_enable, done, done_err, flag_z, flag_n;
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FL = 1;
`else
  localparam bit FL = 0;
`endif
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [7:0] m_rf [4];
  logic m_z = 0, m_n = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dst(req_dst), .req_src1(req_src1), .req_src2(req_src2), .req_imm_sel(req_imm_sel),
    .req_imm(req_imm), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_enable(alu_enable), .alu_result(alu_result),
    .done(done), .done_err(done_err), .done_data(done_data), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << b[2:0];
      default: return 8'h00;
    endcase
  endfunction
  assign alu_result = alu_f(alu_operation, alu_operand1, alu_operand2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic chk_rf();
    for (int i = 0; i < 4; i++) begin
      rf_rd_addr = 2'(i);
      #1 check($sformatf("rf[%0d]", i), rf_rd_data, m_rf[i]);
    end
  endtask

  task automatic chk_flags();
    check("flag_z", flag_z, FL ? m_z : 1'b0);
    check("flag_n", flag_n, FL ? m_n : 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_z = 0;
    m_n = 0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                       input logic [1:0] s2, input logic isel, input logic [7:0] imm);
    logic [7:0] a, b, r;
    int k = 0;
    while (!req_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("ready_before", req_ready, 1);
    a = m_rf[s1];
    b = isel ? imm : m_rf[s2];
    r = alu_f(op, a, b);
    req_op = op; req_dst = d; req_src1 = s1; req_src2 = s2; req_imm_sel = isel; req_imm = imm;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    check("ready_busy", req_ready, 0);
    if (op != 3'b111) begin
      check("en_issue", alu_enable, 1);
      check("done_early", done, 0);
      check("bus_op", alu_operation, op);
      check("bus_a", alu_operand1, a);
      check("bus_b", alu_operand2, b);
      @(negedge clk);
      m_rf[d] = r;
      m_z = r == 8'h00;
      m_n = r[7];
      check("en_done", alu_enable, 0);
      check("ready_done", req_ready, 0);
    end else check("en_illegal", alu_enable, 0);
    check("done", done, 1);
    check("done_err", done_err, op == 3'b111);
    check("done_data", done_data, op == 3'b111 ? 8'h00 : r);
    @(negedge clk);
    check("done_once", done, 0);
    check("ready_back", req_ready, 1);
    chk_flags();
    chk_rf();
  endtask

  initial begin
    int acc, last;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_ready", req_ready, 1);
    check("rst_en", alu_enable, 0);
    check("rst_done", done, 0);
    check("rst_data", done_data, 0);
    chk_flags();
    chk_rf();
    do_op(3'd3, 2'd1, 2'd0, 2'd0, 1, 8'h0D);
    do_op(3'd3, 2'd2, 2'd0, 2'd0, 1, 8'h03);
    do_op(3'd0, 2'd3, 2'd1, 2'd2, 0, 8'h00);
    check("add_r3", m_rf[3], 8'h10);
    do_op(3'd1, 2'd3, 2'd1, 2'd2, 0, 8'h00);
    do_op(3'd2, 2'd3, 2'd1, 2'd2, 0, 8'h00);
    do_op(3'd3, 2'd3, 2'd1, 2'd2, 0, 8'h00);
    do_op(3'd1, 2'd0, 2'd2, 2'd0, 1, 8'h03);
    do_op(3'd3, 2'd1, 2'd0, 2'd0, 1, 8'hFF);
    do_op(3'd0, 2'd3, 2'd1, 2'd0, 1, 8'h01);
    do_op(3'd3, 2'd1, 2'd0, 2'd0, 1, 8'h7F);
    do_op(3'd0, 2'd3, 2'd1, 2'd0, 1, 8'h01);
    do_op(3'd7, 2'd2, 2'd1, 2'd3, 0, 8'h55);
    do_op(3'd0, 2'd2, 2'd2, 2'd2, 0, 8'h00);
    // back-to-back: valid held high across four accumulating adds
    req_op = 3'd0; req_dst = 2'd3; req_src1 = 2'd3; req_imm_sel = 1; req_imm = 8'h01;
    req_valid = 1;
    acc = 0;
    last = 0;
    for (int t = 0; t < 20 && acc < 4; t++) begin
      if (t > 0) @(negedge clk);
      if (req_ready) begin
        if (acc > 0) check("gap", 32'(cyc - last), 3);
        last = cyc;
        acc++;
        m_rf[3] = m_rf[3] + 8'h01;
        m_z = m_rf[3] == 8'h00;
        m_n = m_rf[3][7];
      end else check("busy", alu_enable | done, 1);
    end
    check("accepts", acc, 4);
    @(negedge clk);
    req_valid = 0;
    repeat (2) @(negedge clk);
    check("ready_end", req_ready, 1);
    chk_flags();
    chk_rf();
    // reset during ISSUE drops the operation
    req_op = 3'd0; req_dst = 2'd3; req_src1 = 2'd1; req_src2 = 2'd2; req_imm_sel = 0;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    check("mid_en", alu_enable, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    check("mid_ready", req_ready, 1);
    check("mid_en0", alu_enable, 0);
    check("mid_done", done, 0);
    check("mid_err", done_err, 0);
    check("mid_data", done_data, 0);
    check("mid_a", alu_operand1, 0);
    check("mid_b", alu_operand2, 0);
    check("mid_op", alu_operation, 0);
    chk_flags();
    @(negedge clk);
    check("mid_nodone", done, 0);
    chk_rf();
    for (int i = 0; i < 25; i++)
      do_op(3'($urandom_range(7)), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issuing side of the 8-bit ALU interface: accepts one operation request per handshake, reads operands from a 4×8 register file (or an immediate), and drives `operand1/operand2/operation/enable` into the combinational `alu`. It captures `result` back into the destination register and reports completion. It sits between instruction decode and the ALU and owns the ALU's input bus exclusively.

## Interface
- `NREGS`, 4: register-file depth; fixed power of two, address width `$clog2(NREGS)` = 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  3  ALU operation code.
- `req_dst`, `req_src1`, `req_src2`  in  2 each  register indices.
- `req_imm_sel`  in  1  1 = `operand2` comes from `req_imm` instead of `rf[req_src2]`.
- `req_imm`  in  8  immediate operand.
- `alu_operand1`, `alu_operand2`  out  8 each  ALU inputs.
- `alu_operation`  out  3  ALU opcode.
- `alu_enable`  out  1  ALU enable.
- `alu_result`  in  8  ALU output (combinational).
- `done`  out  1  one-cycle completion pulse.
- `done_err`  out  1  valid with `done`; 1 = illegal opcode.
- `done_data`  out  8  result written; valid with `done`.
- `rf_rd_addr`  in  2  debug read address.
- `rf_rd_data`  out  8  `rf[rf_rd_addr]`, combinational.
- `flag_z`, `flag_n`  out  1 each  zero and sign flags (see Configuration).

## Operation
- FSM states: IDLE → ISSUE → DONE → IDLE. An illegal opcode goes IDLE → DONE directly.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `req_op`, `req_dst`, `rf[req_src1]`, and either `req_imm_sel ? req_imm : rf[req_src2]` into the operand registers.
- ISSUE:
  - `alu_enable` = 1.
  - `alu_operand1/2` and `alu_operation` are driven from the latched registers.
  - At the end of the cycle: `rf[dst] <= alu_result`, `done_data <= alu_result`, update flags.
- DONE:
  - `done` = 1, `req_ready` = 0; return to IDLE.
- Illegal opcode (`3'b111`):
  - ALU is never enabled and `rf` is not written.
  - `done` pulses with `done_err` = 1 and `done_data` = 0.
- Operand bus outside ISSUE:
  - `alu_enable` = 0.
  - `alu_operand1/2` and `alu_operation` hold their last latched values; they do not toggle.
- `dst` equal to a source: operands are captured at accept, so the old value is used and then overwritten.
- Arithmetic: all 8-bit and modulo 256. The sequencer does no arithmetic itself; carry is not visible.
- Reset (any state, including mid-ISSUE or DONE):
  - FSM → IDLE; all `rf` entries and operand/opcode latches → 0.
  - `alu_enable`, `done`, `done_err`, `done_data`, `flag_z`, `flag_n` → 0.
  - The in-flight operation is dropped with no `rf` write and no `done`.
  - `req_ready` = 1 in the first cycle after `rst` deasserts.

## Timing
- Accept at edge N:
  - `alu_enable` is high for cycle N..N+1.
  - `rf` is written at edge N+1.
  - `done` is high for cycle N+1..N+2.
  - `req_ready` returns at edge N+2.
- Throughput: one legal operation per 3 cycles; one illegal operation per 2 cycles.
- `req_ready` is a function of state only, never of `req_valid`.
- `rf_rd_data` reflects a write from the cycle after the write edge.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined:
  - `flag_z` = (result == 0) and `flag_n` = result[7], registered at the `rf` write edge.
  - Flags hold their value across illegal operations.
- Not defined: `flag_z` and `flag_n` are tied to 0 and no flag flops exist.

## Structure
- Package `cpu_pkg` holds the opcode constants:
  - `OP_ADD` = 000, `OP_SUB` = 001, `OP_AND` = 010, `OP_OR` = 011, `OP_XOR` = 100, `OP_NOT` = 101, `OP_SHL` = 110, `OP_ILLEGAL` = 111.
  - Also holds the FSM state enum and the `DATA_W` = 8 constant.
- One sub-module, `regfile4x8`: synchronous write, combinational dual read plus the debug read port, synchronous reset to zero.

## Test plan
- Load r1 with `OR r0, imm 0x0D` and r2 with `OR r0, imm 0x03`, bench wired to the real `alu` → `rf_rd_data` for r1 = 0x0D and for r2 = 0x03; `done` pulses exactly once per operation, 2 cycles after accept.
- `ADD r3 = r1, r2` → 0x10. `SUB` → 0x0A. `AND` → 0x01. `OR` → 0x0F. Check `alu_enable` high for exactly 1 cycle per operation.
- `SUB r0 = r2, imm 0x03` → 0x00 with `flag_z` = 1 when `ALU_SEQ_FLAGS_EN` is defined, and 0 when it is not. `ADD 0xFF + 0x01` → 0x00; `ADD 0x7F + 0x01` → 0x80 with `flag_n` = 1.
- `req_op` = 111 → `done` with `done_err` = 1, `alu_enable` never asserted, all `rf` unchanged, `req_ready` back 2 cycles after accept.
- `req_valid` held high continuously for 4 operations → accepts exactly 3 cycles apart, and `req_ready` = 0 during ISSUE and DONE.
- Assert `rst` during ISSUE of `ADD r3` → r3 stays 0, no `done` pulse, all outputs 0, `req_ready` = 1 in the first cycle after `rst` deasserts.
